alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 64-bit integer ALU between two requesters, the execute-stage issue path (port 0) and the address-generation path (port 1), with round-robin arbitration. Each accepted operation runs on the combinational ALU and its result and zero flag are captured in a one-entry response register with a valid/ready handshake. Saturating per-port grant counters support performance monitoring.

## Interface
- WIDTH, 64, operand/result width
- CNT_W, 32, grant counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op1, req0_op2, req1_op1, req1_op2  in  WIDTH  operands
- req0_sel, req1_sel  in  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response when rsp_valid&rsp_ready
- rsp_id  out  1  port that issued the response
- rsp_result  out  WIDTH  ALU result
- rsp_zero  out  1  result == 0
- rsp_illegal  out  1  sel was not one of the four legal codes
- gnt_cnt0, gnt_cnt1  out  CNT_W  accepted operations per port, saturating
- clr_cnt  in  1  synchronous clear of both counters

## Operation
- slot_free = ~rsp_valid | rsp_ready (response register empty or draining this cycle).
- Grant (combinational): only one valid -> that port; both valid -> port != last_gnt; none -> no grant.
- reqN_ready = slot_free & grant==N; never both high. Ready may depend on valid (grant is combinational on valid); requesters must not make valid depend on ready.
- On accept: ALU evaluated on granted operands/sel; rsp_result, rsp_zero, rsp_id, rsp_illegal loaded; rsp_valid set; last_gnt <= granted port; granted counter increments.
- Illegal sel: result 0, zero 1, illegal 1; still counts as accepted and as a grant.
- Response drained without new accept: rsp_valid cleared; data regs hold their stale values.
- Counters: increment on accept, hold at all-ones; clr_cnt takes priority over increment in the same cycle.
- last_gnt changes only on accept; a stalled response never rotates priority.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 1, rsp_illegal 0, counters 0, last_gnt 1 (port 0 wins the first contention).
- Latency: accept in cycle N -> rsp_valid high from cycle N+1.
- Throughput: one operation per cycle while rsp_ready held high (accept and drain in the same cycle).
- Backpressure: rsp_valid & ~rsp_ready -> both readies low; response outputs stable until taken.
- Both ports continuously valid with rsp_ready high -> strict alternation 0,1,0,1...
- Reset asserted mid-operation: pending response discarded immediately (asynchronous), no partial state kept.

## Structure
- Shared package alu_pkg: 4-bit ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB) and the legal-op check function, shared with the decoder.
- One sub-module: alu, the existing combinational ALU with a 4-bit select input, instantiated once on the muxed operands. Arbiter, response register and counters stay in this module.

## Test plan
- Single op: port 0, op1=5, op2=3, sel=0010, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=8, zero=0, gnt_cnt0=1.
- Zero flag: port 1, op1=op2=64'h1234, sel=0110 -> result=0, zero=1, id=1.
- Contention after reset: both valid, rsp_ready=1 for 4 cycles -> ids 0,1,0,1; gnt_cnt0=gnt_cnt1=2.
- Backpressure: rsp_ready=0 after one accept -> both readies low, outputs held 3 cycles; raising rsp_ready -> drain and new accept in same cycle, next result follows.
- Illegal op: sel=0111, op1=op2=all-ones -> result=0, zero=1, illegal=1, counter increments.
- Reset/saturation: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; counter preloaded near all-ones via CNT_W=4 and 20 accepts -> holds at 15; clr_cnt with simultaneous accept -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the legal-op check used by
// both the ALU and the arbiter's response decoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // True when sel is one of the four supported operations.
  function automatic logic is_legal_op(input logic [3:0] sel);
    return (sel == ALU_AND) || (sel == ALU_OR) ||
           (sel == ALU_ADD) || (sel == ALU_SUB);
  endfunction

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational integer ALU with a 4-bit operation select.
// Unsupported selects produce a zero result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Operation decode and zero detect.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    result = '0;
    case (sel)
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule : alu

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared ALU. Accepted operations are
// captured in a single response register drained by a valid/ready handshake;
// per-port saturating grant counters feed performance monitoring.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [3:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             last_gnt;
  logic             slot_free;
  logic             gnt_any;
  logic             gnt_port;
  logic             accept;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Round-robin grant: a lone requester wins, contention goes to the port
  // that was not granted last.
  always_comb begin
    gnt_any  = req0_valid | req1_valid;
    gnt_port = 1'b0;
    if (req0_valid && req1_valid) gnt_port = ~last_gnt;
    else if (req1_valid)          gnt_port = 1'b1;
  end

  // The response slot can take a new result when empty or draining now.
  assign slot_free  = ~rsp_valid | rsp_ready;
  assign accept     = slot_free & gnt_any;
  assign req0_ready = accept & ~gnt_port;
  assign req1_ready = accept &  gnt_port;

  assign alu_op1 = gnt_port ? req1_op1 : req0_op1;
  assign alu_op2 = gnt_port ? req1_op2 : req0_op2;
  assign alu_sel = gnt_port ? req1_sel : req0_sel;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .sel    (alu_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Response register and priority pointer; data holds when drained idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b1;
      rsp_illegal <= 1'b0;
      last_gnt    <= 1'b1;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      rsp_valid   <= 1'b1;
      rsp_id      <= gnt_port;
      rsp_result  <= alu_result;
      rsp_zero    <= alu_zero;
      rsp_illegal <= ~is_legal_op(alu_sel);
      last_gnt    <= gnt_port;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (clr_cnt) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt_port && gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if ( gnt_port && gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a 4-bit counter build to reach
// saturation quickly.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]       req0_sel, req1_sel;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [WIDTH-1:0] rsp_result;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
  logic             clr_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .req0_sel    (req0_sel),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .req1_sel    (req1_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1),
    .clr_cnt     (clr_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_id;
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_sel = ALU_AND;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_sel = ALU_AND;
    rsp_ready  = 1'b1;
    clr_cnt    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   rsp_valid,   1'b0);
    check("rst_id",      rsp_id,      1'b0);
    check("rst_result",  rsp_result,  64'h0);
    check("rst_zero",    rsp_zero,    1'b1);
    check("rst_illegal", rsp_illegal, 1'b0);
    check("rst_cnt0",    gnt_cnt0,    4'd0);
    check("rst_cnt1",    gnt_cnt1,    4'd0);
    rst_n = 1'b1;
    tick();

    // Single ADD on port 0
    req0_valid = 1'b1; req0_op1 = 64'd5; req0_op2 = 64'd3; req0_sel = ALU_ADD;
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    check("single_valid",  rsp_valid,   1'b1);
    check("single_id",     rsp_id,      1'b0);
    check("single_result", rsp_result,  64'd8);
    check("single_zero",   rsp_zero,    1'b0);
    check("single_ill",    rsp_illegal, 1'b0);
    check("single_cnt0",   gnt_cnt0,    4'd1);
    tick();
    check("drain_valid",   rsp_valid,   1'b0);
    check("drain_stale",   rsp_result,  64'd8);

    // Zero flag via SUB on port 1
    req1_valid = 1'b1; req1_op1 = 64'h1234; req1_op2 = 64'h1234; req1_sel = ALU_SUB;
    tick();
    req1_valid = 1'b0;
    check("zero_result", rsp_result, 64'h0);
    check("zero_flag",   rsp_zero,   1'b1);
    check("zero_id",     rsp_id,     1'b1);
    check("zero_cnt1",   gnt_cnt1,   4'd1);

    // Clear counters, then contend: port 0 wins first (last grant was port 1)
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_cnt0", gnt_cnt0, 4'd0);
    check("clr_cnt1", gnt_cnt1, 4'd0);
    req0_valid = 1'b1; req0_op1 = 64'd10;  req0_op2 = 64'd1;  req0_sel = ALU_ADD;
    req1_valid = 1'b1; req1_op1 = 64'hF0;  req1_op2 = 64'h0F; req1_sel = ALU_OR;
    exp_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_id",     rsp_id,     exp_id);
      check("rr_result", rsp_result, exp_id ? 64'hFF : 64'd11);
      exp_id = ~exp_id;
    end
    check("rr_cnt0", gnt_cnt0, 4'd2);
    check("rr_cnt1", gnt_cnt1, 4'd2);

    // Backpressure: hold port-1 response three cycles
    rsp_ready = 1'b0;
    #1;
    check("bp_ready0", req0_ready, 1'b0);
    check("bp_ready1", req1_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid",  rsp_valid,  1'b1);
      check("bp_id",     rsp_id,     1'b1);
      check("bp_result", rsp_result, 64'hFF);
      check("bp_cnt0",   gnt_cnt0,   4'd2);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready0", req0_ready, 1'b1);
    check("bp_release_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("bp_next_valid",  rsp_valid,  1'b1);
    check("bp_next_id",     rsp_id,     1'b0);
    check("bp_next_result", rsp_result, 64'd11);
    check("bp_next_cnt0",   gnt_cnt0,   4'd3);

    // Illegal select
    req0_valid = 1'b1; req0_op1 = '1; req0_op2 = '1; req0_sel = 4'b0111;
    tick();
    req0_valid = 1'b0;
    check("ill_result",  rsp_result,  64'h0);
    check("ill_zero",    rsp_zero,    1'b1);
    check("ill_flag",    rsp_illegal, 1'b1);
    check("ill_cnt0",    gnt_cnt0,    4'd4);

    // Saturation: 20 back-to-back AND ops on port 1
    req1_valid = 1'b1; req1_op1 = 64'hFF00; req1_op2 = 64'h0FF0; req1_sel = ALU_AND;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt1",    gnt_cnt1,    4'd15);
    check("sat_result",  rsp_result,  64'h0F00);
    check("sat_illegal", rsp_illegal, 1'b0);

    // Clear takes priority over a simultaneous accept
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clracc_cnt1",  gnt_cnt1,  4'd0);
    check("clracc_cnt0",  gnt_cnt0,  4'd0);
    check("clracc_valid", rsp_valid, 1'b1);

    // Asynchronous reset discards a stalled response
    rsp_ready = 1'b0; req1_valid = 1'b0;
    tick();
    check("hold_valid", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",  rsp_valid,  1'b0);
    check("arst_result", rsp_result, 64'h0);
    check("arst_zero",   rsp_zero,   1'b1);
    check("arst_id",     rsp_id,     1'b0);
    tick();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_arbiter
